// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helper for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_STAGGER,
    ST_RELEASE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Width of the shared FSM counter: wide enough for the largest interval.
  function automatic int cnt_w(input int hold, input int stag, input int deb, input int tmo);
    int m;
    m = hold;
    if (stag > m) m = stag;
    if (deb > m) m = deb;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Board reset button: 2-flop synchroniser, polarity normalisation, debounce.
module btn_sync_debounce #(
  parameter int DEBOUNCE    = 16,
  parameter bit BTN_ACT_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pressed_o
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);

  logic          s1, s2;
  logic          norm;
  logic [DW-1:0] cnt;

  assign norm = s2 ^ BTN_ACT_LOW;

  // The debounced level flips only after DEBOUNCE consecutive opposite samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= BTN_ACT_LOW;
      s2        <= BTN_ACT_LOW;
      cnt       <= '0;
      pressed_o <= 1'b1;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
      if (norm == pressed_o) begin
        cnt <= '0;
      end else if (cnt >= DEB_LAST) begin
        cnt       <= '0;
        pressed_o <= norm;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds all domains in reset, then releases them in
// index order with a stagger gap and a per-domain ready handshake.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 64,
  parameter int STAGGER     = 8,
  parameter int DEBOUNCE    = 16,
  parameter bit BTN_ACT_LOW = 1'b0,
  parameter int TIMEOUT     = 4096,
  parameter int CNT_W       = cnt_w(HOLD_CYCLES, STAGGER, DEBOUNCE, TIMEOUT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_i,
  input  logic [N_STAGES-1:0]           ready_i,
  output logic [N_STAGES-1:0]           rst_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic [$clog2(N_STAGES+1)-1:0] stage_o
);
  localparam int SW = $clog2(N_STAGES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [SW-1:0]       k, k_nx;
  logic [N_STAGES-1:0] rst_nx;
  logic                to_nx;
  logic                pressed;

  btn_sync_debounce #(
    .DEBOUNCE   (DEBOUNCE),
    .BTN_ACT_LOW(BTN_ACT_LOW)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_i),
    .pressed_o(pressed)
  );

  always_comb begin
    state_nx = state;
    k_nx     = k;
    rst_nx   = rst_o;
    to_nx    = timeout_o;
    cnt_nx   = (cnt == '1) ? cnt : cnt + 1'b1;
    // A debounced press outside HOLD aborts the whole sequence.
    if (pressed && state != ST_HOLD) begin
      state_nx = ST_HOLD;
      k_nx     = '0;
      rst_nx   = '1;
      to_nx    = 1'b0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          rst_nx = '1;
          if (pressed) begin
            cnt_nx = '0;
          end else if (cnt >= HOLD_LAST) begin
            state_nx = ST_STAGGER;
            k_nx     = '0;
          end
        end
        ST_STAGGER: if (cnt >= STAG_LAST) state_nx = ST_RELEASE;
        ST_RELEASE: begin
          rst_nx[k] = 1'b0;
          state_nx  = ST_WAIT;
        end
        ST_WAIT: begin
          if (ready_i[k] || (TIMEOUT != 0 && cnt >= TO_LAST)) begin
            if (!ready_i[k]) to_nx = 1'b1;
            if (k == SW'(N_STAGES - 1)) begin
              state_nx = ST_DONE;
            end else begin
              k_nx     = k + 1'b1;
              state_nx = ST_STAGGER;
            end
          end
        end
        ST_DONE: rst_nx = '0;
        default: state_nx = ST_HOLD;
      endcase
    end
    if (state_nx != state) cnt_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      k         <= '0;
      rst_o     <= '1;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      stage_o   <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      k         <= k_nx;
      rst_o     <= rst_nx;
      timeout_o <= to_nx;
      done_o    <= (state_nx == ST_DONE);
      stage_o   <= (state_nx == ST_DONE) ? SW'(N_STAGES) : k_nx;
    end
  end

  // Release is strictly in index order: a released domain implies all lower ones released.
  a_release_order: assert property (@(posedge clk) disable iff (rst)
    ((~rst_o) & ((~rst_o) + 1'b1)) == '0);

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench: directed scenarios plus random button/ready/reset traffic
// checked every cycle against a behavioural model of the release sequence.
module tb_rst_sequencer;
  localparam int N       = 3;
  localparam int HOLD    = 64;
  localparam int STAG    = 8;
  localparam int DEB     = 16;
  localparam int TO      = 32;
  localparam bit ACT_LOW = 1'b1;
  localparam int SW      = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn = ACT_LOW;
  logic [N-1:0]  ready = '1;
  logic [N-1:0]  rst_o;
  logic          done_o, timeout_o;
  logic [SW-1:0] stage_o;

  int vecs = 0;
  int errs = 0;

  rst_sequencer #(
    .N_STAGES(N), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .DEBOUNCE(DEB),
    .BTN_ACT_LOW(ACT_LOW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn), .ready_i(ready),
    .rst_o(rst_o), .done_o(done_o), .timeout_o(timeout_o), .stage_o(stage_o)
  );

  always #5 clk = ~clk;

  // Reference model: number of released domains, countdown to next release,
  // and the debounced button as "last DEB synced samples all disagree".
  bit m_hold, m_waiting, m_done, m_to, m_pressed, m_s1, m_s2;
  int hold_cnt, togo, wcnt, nrel;
  bit hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_order(input logic [N-1:0] r);
    for (int j = 0; j < N; j++)
      for (int i = 0; i < j; i++)
        if (!r[j] && r[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    bit nb, all_diff;
    if (rst) begin
      m_hold = 1; m_waiting = 0; m_done = 0; m_to = 0; m_pressed = 1;
      hold_cnt = 0; togo = 0; wcnt = 0; nrel = 0;
      m_s1 = ACT_LOW; m_s2 = ACT_LOW; hist.delete();
      return;
    end
    if (m_pressed && !m_hold) begin
      m_hold = 1; hold_cnt = 0; nrel = 0; m_done = 0; m_to = 0; togo = 0; m_waiting = 0;
    end else if (m_hold) begin
      if (m_pressed) hold_cnt = 0;
      else if (hold_cnt >= HOLD - 1) begin m_hold = 0; togo = STAG + 1; end
      else hold_cnt++;
    end else if (togo > 0) begin
      togo--;
      if (togo == 0) begin nrel++; m_waiting = 1; wcnt = 0; end
    end else if (m_waiting) begin
      if (ready[nrel-1] || wcnt >= TO - 1) begin
        if (!ready[nrel-1]) m_to = 1;
        m_waiting = 0;
        if (nrel == N) m_done = 1;
        else togo = STAG + 1;
      end else wcnt++;
    end
    nb = m_s2 ^ ACT_LOW;
    m_s2 = m_s1;
    m_s1 = btn;
    hist.push_back(nb);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_diff = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] == m_pressed) all_diff = 0;
    if (all_diff) begin m_pressed = !m_pressed; hist.delete(); end
  endtask

  task automatic step();
    logic [N-1:0] e_rst;
    int e_stage;
    @(posedge clk);
    model_update();
    @(negedge clk);
    e_rst   = N'(((1 << N) - 1) & ~((1 << nrel) - 1));
    e_stage = m_done ? N : (m_waiting ? nrel - 1 : nrel);
    chk("rst_o", rst_o, e_rst);
    chk("done_o", done_o, m_done);
    chk("timeout_o", timeout_o, m_to);
    chk("stage_o", stage_o, e_stage);
    chk("order", in_order(rst_o), 1);
  endtask

  task automatic run_until_rst(input logic [N-1:0] val, output int n);
    n = 0;
    while (rst_o !== val && n < 400) begin step(); n++; end
    if (rst_o !== val) n = -1;
  endtask

  task automatic press(input bit p);
    btn = ACT_LOW ^ p;
  endtask

  initial begin
    int n, blen;
    // Power-on reset with all domains ready
    rst = 1; repeat (5) step();
    chk("reset_rst_o", rst_o, 3'b111);
    chk("reset_stage", stage_o, 0);
    rst = 0;
    // Button is debounced-pressed out of reset, so hold starts after DEB cycles
    run_until_rst(3'b110, n); chk("rel0_lat", n, DEB + HOLD + STAG + 1);
    run_until_rst(3'b100, n); chk("rel1_gap", n, STAG + 2);
    run_until_rst(3'b000, n); chk("rel2_gap", n, STAG + 2);
    step(); chk("done", done_o, 1); chk("done_stage", stage_o, N);

    // Stage 1 ready delayed below the timeout
    rst = 1; repeat (2) step(); rst = 0; ready = 3'b101;
    run_until_rst(3'b100, n);
    repeat (20) step();
    chk("s2_held", rst_o, 3'b100);
    ready = 3'b111; step();
    run_until_rst(3'b000, n); chk("s2_lat", n, STAG + 1);
    chk("s2_no_to", timeout_o, 0);
    step(); chk("s2_done", done_o, 1);

    // Stage 1 never ready: timeout then continue
    rst = 1; repeat (2) step(); rst = 0; ready = 3'b101;
    run_until_rst(3'b100, n);
    n = 0;
    while (!timeout_o && n < 100) begin step(); n++; end
    chk("s3_to_lat", n, TO);
    run_until_rst(3'b000, n); step();
    chk("s3_done", done_o, 1); chk("s3_to_sticky", timeout_o, 1);

    // Short glitch ignored, long press re-asserts everything
    press(1); repeat (10) step(); press(0); repeat (30) step();
    chk("glitch_rst", rst_o, 3'b000); chk("glitch_done", done_o, 1);
    press(1); run_until_rst(3'b111, n); chk("press_lat", n, DEB + 3);
    chk("press_to_clr", timeout_o, 0);
    repeat (40 - DEB - 3) step(); press(0);
    run_until_rst(3'b110, n); chk("reseq_lat", n, DEB + 2 + HOLD + STAG + 1);

    // Press while waiting on stage 1
    run_until_rst(3'b100, n);
    press(1); run_until_rst(3'b111, n); chk("abort_lat", n, DEB + 3);
    chk("abort_stage", stage_o, 0); press(0);

    // Sync reset in WAIT of stage 2
    ready = 3'b011;
    run_until_rst(3'b000, n); repeat (3) step();
    rst = 1; step();
    chk("rst_mid_rst", rst_o, 3'b111); chk("rst_mid_stage", stage_o, 0);
    chk("rst_mid_done", done_o, 0); rst = 0;

    // Random traffic
    blen = 0;
    for (int e = 0; e < 25; e++) begin
      int len;
      logic [N-1:0] stuck;
      len   = $urandom_range(120, 320);
      stuck = (e % 3 == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) ready = N'($urandom) & ~stuck;
        if (blen > 0) begin
          blen--;
          if (blen == 0) press(0);
        end else if ($urandom_range(0, 60) == 0) begin
          blen = $urandom_range(3, 40);
          press(1);
        end
        rst = ($urandom_range(0, 400) == 0);
        step();
      end
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
